// File: rtl/param_universal_shiftreg.sv
// ============================================================================
// param_universal_shiftreg : parametrised universal shift/rotate register with
// a self-timed LSB-first serialize burst.                          Rev 1.0
// ============================================================================
`default_nettype none

module param_universal_shiftreg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             sync_reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_in_right,
  input  logic             ser_in_left,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [2:0] C_HOLD  = 3'b000;
  localparam logic [2:0] C_SHL   = 3'b001;
  localparam logic [2:0] C_SHR   = 3'b010;
  localparam logic [2:0] C_LOAD  = 3'b011;
  localparam logic [2:0] C_ROL   = 3'b100;
  localparam logic [2:0] C_ROR   = 3'b101;
  localparam logic [2:0] C_ASR   = 3'b110;
  localparam logic [2:0] C_BURST = 3'b111;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_data, w_data_nx;
  logic [AMT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;

  logic [AMT_W-1:0]   w_rot_k;
  logic [WIDTH-1:0]   w_lmask, w_rmask;
  logic [WIDTH-1:0]   w_shl, w_shr, w_asr, w_rol, w_ror;
  logic [2*WIDTH-1:0] w_dbl_l, w_dbl_r;

  // Masks mark vacated positions; a shift by k >= WIDTH yields an all-ones mask.
  always_comb begin
    w_rot_k = AMT_W'(amt % WIDTH);
    w_lmask = ~({WIDTH{1'b1}} << amt);
    w_rmask = ~({WIDTH{1'b1}} >> amt);
    w_shl   = (r_data << amt) | (w_lmask & {WIDTH{ser_in_left}});
    w_shr   = (r_data >> amt) | (w_rmask & {WIDTH{ser_in_right}});
    w_asr   = (r_data >> amt) | (w_rmask & {WIDTH{r_data[WIDTH-1]}});
    w_dbl_l = {r_data, r_data} << w_rot_k;
    w_dbl_r = {r_data, r_data} >> w_rot_k;
    w_rol   = w_dbl_l[2*WIDTH-1:WIDTH];
    w_ror   = w_dbl_r[WIDTH-1:0];
  end

  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    if (sync_reset) begin
      w_state_nx = IDLE;
      w_data_nx  = '0;
      w_busy_nx  = 1'b0;
    end else if (r_state == SHIFT) begin
      if (r_cnt != '0) begin
        w_data_nx = {ser_in_right, r_data[WIDTH-1:1]};
        w_cnt_nx  = r_cnt - 1'b1;
      end else begin
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b1;
        w_state_nx = IDLE;
      end
    end else if (enable) begin
      case (mode)
        C_HOLD:  w_data_nx = r_data;
        C_SHL:   w_data_nx = w_shl;
        C_SHR:   w_data_nx = w_shr;
        C_LOAD:  w_data_nx = in;
        C_ROL:   w_data_nx = w_rol;
        C_ROR:   w_data_nx = w_ror;
        C_ASR:   w_data_nx = w_asr;
        C_BURST: begin
          w_data_nx  = in;
          w_cnt_nx   = AMT_W'(WIDTH - 1);
          w_busy_nx  = 1'b1;
          w_state_nx = SHIFT;
        end
        default: w_data_nx = r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign out         = r_data;
  assign ser_out_msb = r_data[WIDTH-1];
  assign ser_out_lsb = r_data[0];
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_param_universal_shiftreg.sv
// ============================================================================
// tb_param_universal_shiftreg : directed self-checking bench, WIDTH=8 and 5.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_param_universal_shiftreg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       srst = 1'b0;

  logic       en8 = 1'b0, sr8 = 1'b0, sl8 = 1'b0;
  logic [2:0] mode8 = 3'b000;
  logic [2:0] amt8 = 3'd0;
  logic [7:0] in8 = 8'h00;
  logic [7:0] out8;
  logic       msb8, lsb8, busy8, done8;

  logic       en5 = 1'b0, sr5 = 1'b0, sl5 = 1'b0;
  logic [2:0] mode5 = 3'b000;
  logic [2:0] amt5 = 3'd0;
  logic [4:0] in5 = 5'h00;
  logic [4:0] out5;
  logic       msb5, lsb5, busy5, done5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  param_universal_shiftreg #(.WIDTH(8)) dut8 (
    .clk(clk), .async_reset_n(rst_n), .sync_reset(srst), .enable(en8),
    .mode(mode8), .amt(amt8), .in(in8), .ser_in_right(sr8), .ser_in_left(sl8),
    .out(out8), .ser_out_msb(msb8), .ser_out_lsb(lsb8), .busy(busy8), .done(done8)
  );

  param_universal_shiftreg #(.WIDTH(5)) dut5 (
    .clk(clk), .async_reset_n(rst_n), .sync_reset(srst), .enable(en5),
    .mode(mode5), .amt(amt5), .in(in5), .ser_in_right(sr5), .ser_in_left(sl5),
    .out(out5), .ser_out_msb(msb5), .ser_out_lsb(lsb5), .busy(busy5), .done(done5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [2:0] m, input logic [2:0] k, input logic [7:0] d);
    en8 = 1'b1; mode8 = m; amt8 = k; in8 = d;
    step();
    en8 = 1'b0;
  endtask

  logic [7:0] burst_word;
  logic       done_seen;

  initial begin
    #12 rst_n = 1'b1;
    #1;
    chk("reset_out", out8, 8'h00);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_done", done8, 1'b0);

    // Basic shifts
    op8(3'b011, 3'd0, 8'hBD);       chk("load", out8, 8'hBD);
    sr8 = 1'b1;
    op8(3'b010, 3'd1, 8'h00);       chk("shr1_fill1", out8, 8'hDE);
    sl8 = 1'b0;
    op8(3'b001, 3'd2, 8'h00);       chk("shl2_fill0", out8, 8'h78);
    op8(3'b000, 3'd5, 8'hFF);       chk("hold", out8, 8'h78);
    chk("ser_msb", msb8, 1'b0);

    // Enable gating and k=0
    en8 = 1'b0; mode8 = 3'b011; in8 = 8'hFF;
    step();                         chk("enable_gate", out8, 8'h78);
    sl8 = 1'b1;
    op8(3'b001, 3'd0, 8'h00);       chk("shl_k0", out8, 8'h78);

    // Rotates and arithmetic shift
    op8(3'b011, 3'd0, 8'h81);       chk("load81", out8, 8'h81);
    op8(3'b100, 3'd3, 8'h00);       chk("rol3", out8, 8'h0C);
    op8(3'b101, 3'd3, 8'h00);       chk("ror3", out8, 8'h81);
    op8(3'b110, 3'd4, 8'h00);       chk("asr4", out8, 8'hF8);

    // Burst with mode change inside
    sr8 = 1'b0;
    burst_word = 8'hB4;
    en8 = 1'b1; mode8 = 3'b111; in8 = burst_word;
    step();
    mode8 = 3'b011; in8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst_lsb%0d", i), lsb8, burst_word[i]);
      chk($sformatf("burst_busy%0d", i), busy8, 1'b1);
      chk($sformatf("burst_done%0d", i), done8, 1'b0);
      if (i == 7) begin
        mode8 = 3'b111; in8 = 8'h5A;  // back-to-back request presented in done cycle
      end
      step();
    end
    chk("burst_end_busy", busy8, 1'b0);
    chk("burst_end_done", done8, 1'b1);
    chk("burst_end_out", out8, 8'h01);
    step();
    en8 = 1'b0;
    chk("b2b_busy", busy8, 1'b1);
    chk("b2b_done", done8, 1'b0);
    chk("b2b_lsb0", lsb8, 1'b0);
    step(); chk("b2b_lsb1", lsb8, 1'b1);
    step(); chk("b2b_lsb2", lsb8, 1'b0);
    step(); chk("b2b_lsb3", lsb8, 1'b1);

    // Abort in cycle 3
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("abort_out", out8, 8'h00);
    chk("abort_busy", busy8, 1'b0);
    done_seen = done8;
    for (int i = 0; i < 10; i++) begin
      step();
      done_seen = done_seen | done8;
    end
    chk("abort_no_done", done_seen, 1'b0);

    // Asynchronous reset mid-cycle
    op8(3'b011, 3'd0, 8'hA5);       chk("loadA5", out8, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", out8, 8'h00);
    chk("async_busy", busy8, 1'b0);
    chk("async_done", done8, 1'b0);
    #1 rst_n = 1'b1;

    // WIDTH=5 oversized shift amount
    en5 = 1'b1; mode5 = 3'b011; in5 = 5'b00100;
    step();                         chk("w5_load", out5, 5'b00100);
    mode5 = 3'b001; amt5 = 3'd6; sl5 = 1'b1;
    step();                         chk("w5_shl6_fill1", out5, 5'b11111);
    mode5 = 3'b010; amt5 = 3'd5; sr5 = 1'b0;
    step();                         chk("w5_shr5_fill0", out5, 5'b00000);
    mode5 = 3'b011; in5 = 5'b10011;
    step();
    mode5 = 3'b100; amt5 = 3'd7;
    step();                         chk("w5_rol7", out5, 5'b01110);
    en5 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_universal_shiftreg.md
Name: param_universal_shiftreg

Overview:
- Parametrised universal shift register; the next generation of the fixed 8-bit hold/shift-left/shift-right/load register.
- Adds configurable width, multi-bit shift amount, rotates, arithmetic right shift, and a self-timed serialize burst with busy/done status.
- Sits between parallel datapaths and bit-serial links; drop-in as a plain shift register when only modes 000-011 are used.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount port. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- async_reset_n  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous active-high clear.
- enable  input  1  qualifies mode in IDLE.
- mode  input  3  operation select; see Behaviour.
- amt  input  AMT_W  shift/rotate amount.
- in  input  WIDTH  parallel load data.
- ser_in_right  input  1  fill bit for vacated MSBs on logical right shift and burst.
- ser_in_left  input  1  fill bit for vacated LSBs on left shift.
- out  output  WIDTH  register contents.
- ser_out_msb  output  1  equals out[WIDTH-1]; combinational.
- ser_out_lsb  output  1  equals out[0]; combinational. Serial output during burst.
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle pulse at burst end.

Behaviour:
- Reset: async_reset_n=0 forces out=0, busy=0, done=0, cnt=0, state=IDLE immediately, independent of clk.
- Priority at each rising edge: sync_reset > burst in progress > enable/mode.
- sync_reset=1: out=0, busy=0, done=0, state=IDLE. This aborts any burst; no done pulse is produced.
- done defaults to 0 every cycle unless set as described below.
- IDLE, enable=0: out holds.
- IDLE, enable=1, mode decode (k = amt):
  - 000: hold.
  - 001: out <= out << k; vacated k LSBs = ser_in_left.
  - 010: out <= out >> k; vacated k MSBs = ser_in_right.
  - 011: out <= in.
  - 100: rotate left by k mod WIDTH.
  - 101: rotate right by k mod WIDTH.
  - 110: arithmetic right shift by k; vacated bits = old out[WIDTH-1].
  - 111: burst start. out <= in, cnt <= WIDTH-1, busy <= 1, state <= SHIFT.
- Shift-amount rules:
  - k=0 leaves out unchanged for modes 001, 010, 100, 101, 110.
  - For shifts (001, 010, 110), k >= WIDTH (possible only when WIDTH is not a power of two) fills every bit with the fill bit.
- SHIFT state, each edge:
  - cnt != 0: out <= {ser_in_right, out[WIDTH-1:1]}, cnt <= cnt-1.
  - cnt == 0: out holds, busy <= 0, done <= 1, state <= IDLE.
  - mode, enable, in and amt are ignored while in SHIFT.
- Burst timing: ser_out_lsb shows in[i] during the i-th cycle after the load edge, for i = 0..WIDTH-1. busy is high for exactly WIDTH cycles; done is high in cycle WIDTH.
- Back-to-back bursts: a mode=111, enable=1 request in the done cycle is accepted, since state is IDLE. busy re-asserts at the next edge.
- All operations are single-cycle; out updates on the edge following a valid command.

Test Plan:
- Reset: drive async_reset_n=0 mid-cycle with out=8'hA5 -> out=8'h00, busy=0, done=0 immediately, without waiting for a clock edge.
- Basic ops, WIDTH=8: load 8'b1011_1101 (mode 011), then mode 010, k=1, ser_in_right=1 -> 8'b1101_1110. Then mode 001, k=2, ser_in_left=0 -> 8'b0111_1000. Then mode 000 -> 8'b0111_1000 unchanged.
- Rotate/arith: load 8'h81. Mode 100, k=3 -> 8'h0C. Mode 101, k=3 -> 8'h81. Mode 110, k=4 -> 8'hF8.
- Burst: mode 111, in=8'hB4, enable=1 for one cycle -> ser_out_lsb sequence 0,0,1,0,1,1,0,1 over 8 cycles. busy=1 for exactly 8 cycles, then done=1 for 1 cycle. Mode changes during the burst have no effect.
- Abort: sync_reset=1 in cycle 3 of a burst -> out=0, busy=0 next edge; done never pulses.
- Enable gating and edge cases: enable=0 with mode 011 -> out unchanged. k=0 with mode 001 -> out unchanged. WIDTH=5, k=6, mode 001, ser_in_left=1 -> out=5'b11111.
